// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider (DIV/DIVU/REM/REMU) feeding the CDB.
// One radix-2 restoring step per cycle on operand magnitudes, sign fix-up on the
// last step, result held until the CDB arbiter acknowledges it.
// Optional feature macro: DIV_SPECIAL_BYPASS_EN -- divide-by-zero and signed
// overflow skip the iterative phase and complete one cycle after issue.
// Handshakes:
//   issue side: an operation transfers on a rising edge where div_start && div_ready
//     and no flush/kill applies; div_ready is high only in IDLE.
//   CDB side:   cdb_req acts as valid, cdb_ack as ready; the result transfers on the
//     edge where both are high. Until then cdb_req and every cdb_* output hold steady.

package div_unit_pkg;
    localparam int EBR_MASK_SIZE = 4;
    localparam int ROB_ID_W      = 6;
    localparam int PRD_W         = 7;
    localparam int LRD_W         = 5;

    typedef struct packed {
        logic [ROB_ID_W-1:0]      rob_id;
        logic [31:0]              prs1_v;
        logic [31:0]              prs2_v;
        logic [PRD_W-1:0]         prd_s;
        logic [LRD_W-1:0]         lrd_s;
        logic [31:0]              inst;
        logic [EBR_MASK_SIZE-1:0] ebr_mask;
        logic                     valid;
    } eu_operand_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;
endpackage

module div_unit
    import div_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     div_start,
    input  eu_operand_t              div_in,
    output logic                     div_ready,
    output logic                     cdb_req,
    input  logic                     cdb_ack,
    output logic [ROB_ID_W-1:0]      cdb_rob_id,
    output logic [PRD_W-1:0]         cdb_prd_s,
    output logic [LRD_W-1:0]         cdb_lrd_s,
    output logic [31:0]              cdb_rd_v,
    input  logic                     late_flush,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id,
    output div_state_t               dbg_state
);

`ifdef DIV_SPECIAL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    div_state_t state_q, state_d;
    logic [4:0]  cnt_q;
    logic [EBR_MASK_SIZE-1:0] mask_q;

    // datapath registers (no reset needed: only observed once written)
    logic [31:0] rem_q, quo_q, dsr_q, dvd_q, res_q;
    logic        neg_quo_q, neg_rem_q, is_rem_q, zero_q;
    logic [ROB_ID_W-1:0] rob_q;
    logic [PRD_W-1:0]    prd_q;
    logic [LRD_W-1:0]    lrd_q;

    // issue-side decode
    logic        op_signed, op_rem;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        in_zero, in_ovf, in_special;
    logic [31:0] special_res;

    // iteration step and final result
    logic [32:0] shifted, diff;
    logic        take;
    logic [31:0] rem_step, quo_step, quo_fin, rem_fin, fin_res;

    // control
    logic accept, kill_in, kill_held;
    logic [EBR_MASK_SIZE-1:0] clr_bits;

    logic unused_in;
    assign unused_in = ^{div_in.valid, div_in.inst[31:15], div_in.inst[11:0], div_in.inst[14]};

    // Decode the incoming operation: signedness, magnitudes and the special cases
    always_comb begin
        op_signed   = ~div_in.inst[12];
        op_rem      = div_in.inst[13];
        a_neg       = op_signed & div_in.prs1_v[31];
        b_neg       = op_signed & div_in.prs2_v[31];
        a_mag       = a_neg ? (32'd0 - div_in.prs1_v) : div_in.prs1_v;
        b_mag       = b_neg ? (32'd0 - div_in.prs2_v) : div_in.prs2_v;
        in_zero     = (div_in.prs2_v == 32'd0);
        in_ovf      = op_signed && (div_in.prs1_v == 32'h8000_0000) &&
                      (div_in.prs2_v == 32'hFFFF_FFFF);
        in_special  = in_zero | in_ovf;
        special_res = 32'd0;
        if (in_zero) begin
            special_res = op_rem ? div_in.prs1_v : 32'hFFFF_FFFF;
        end else begin
            special_res = op_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // Branch resolution: kill tests for held and incoming ops, mask bits to clear
    always_comb begin
        kill_in   = bra_done && bra_mispredict && (|(div_in.ebr_mask & bra_id));
        kill_held = bra_done && bra_mispredict && (|(mask_q & bra_id));
        clr_bits  = (bra_done && !bra_mispredict) ? bra_id : '0;
    end

    // One restoring step plus sign correction for the final step
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dsr_q};
        take     = ~diff[32];
        rem_step = take ? diff[31:0] : shifted[31:0];
        quo_step = {quo_q[30:0], take};
        quo_fin  = neg_quo_q ? (32'd0 - quo_step) : quo_step;
        rem_fin  = neg_rem_q ? (32'd0 - rem_step) : rem_step;
        if (zero_q) begin
            quo_fin = 32'hFFFF_FFFF;
            rem_fin = dvd_q;
        end
        fin_res  = is_rem_q ? rem_fin : quo_fin;
    end

    // Next-state and handshake outputs; flush and held-op kill override everything
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (div_start && !late_flush && !kill_in) begin
                    accept  = 1'b1;
                    state_d = (BYPASS && in_special) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (cnt_q == 5'd0) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (cdb_ack) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (late_flush || ((state_q != DIV_IDLE) && kill_held)) begin
            state_d = DIV_IDLE;
        end
    end

    assign div_ready  = (state_q == DIV_IDLE);
    assign cdb_req    = (state_q == DIV_DONE) && !late_flush && !kill_held;
    assign cdb_rob_id = rob_q;
    assign cdb_prd_s  = prd_q;
    assign cdb_lrd_s  = lrd_q;
    assign cdb_rd_v   = res_q;
    assign dbg_state  = state_q;

    // Control state: FSM, iteration counter and speculative branch mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= 5'd31;
                mask_q <= div_in.ebr_mask & ~clr_bits;
            end else begin
                if ((state_q == DIV_CALC) && (cnt_q != 5'd0)) begin
                    cnt_q <= cnt_q - 5'd1;
                end
                mask_q <= mask_q & ~clr_bits;
            end
        end
    end

    // Datapath: capture operands/tags on accept, iterate in CALC, latch result on last step
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q     <= 32'd0;
            quo_q     <= a_mag;
            dsr_q     <= b_mag;
            dvd_q     <= div_in.prs1_v;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            is_rem_q  <= op_rem;
            zero_q    <= in_zero;
            rob_q     <= div_in.rob_id;
            prd_q     <= div_in.prd_s;
            lrd_q     <= div_in.lrd_s;
            res_q     <= special_res;
        end else if (state_q == DIV_CALC) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            if (cnt_q == 5'd0) begin
                res_q <= fin_res;
            end
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 div_start  input  1  issue stage presents a valid divide operation this cycle.
REQ-004 div_in  input  eu_operand_t  operation: rob_id, prs1_v (dividend), prs2_v (divisor), prd_s, lrd_s, inst, ebr_mask, valid.
REQ-005 div_ready  output  1  unit idle and can accept div_start.
REQ-006 cdb_req  output  1  result valid, requesting a CDB slot.
REQ-007 cdb_ack  input  1  CDB arbiter grants the slot this cycle.
REQ-008 cdb_rob_id, cdb_prd_s, cdb_lrd_s  output  widths of the same-named eu_operand_t fields  tags of the completed operation.
REQ-009 cdb_rd_v  output  32  quotient or remainder.
REQ-010 late_flush  input  1  ROB pipeline flush.
REQ-011 bra_done, bra_mispredict  input  1 each  branch resolution event and its outcome.
REQ-012 bra_id  input  EBR_MASK_SIZE  one-hot tag of the resolving branch.

Function
REQ-013 Operation is selected by div_in.inst[14:12]: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other encodings are never issued to this unit.
REQ-014 FSM states: IDLE, CALC, DONE; div_ready is high only in IDLE.
REQ-015 IDLE: div_start with no kill condition (REQ-021, REQ-022) latches the operands and tags, loads the iteration counter with 31, and moves to CALC.
REQ-016 CALC: one radix-2 restoring step per cycle on 32-bit magnitudes (signed ops use absolute values); after the step with counter 0, result sign correction is applied and the FSM moves to DONE.
REQ-017 Latency: start accepted in cycle 0; CALC occupies cycles 1-32; cdb_req first high in cycle 33.
REQ-018 Signed result signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-019 Divisor 0: quotient 0xFFFFFFFF, remainder = dividend, for signed and unsigned ops. DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-020 DONE: cdb_req and all cdb_* outputs are held stable until cdb_ack; the cycle with cdb_ack high is the handoff, and the FSM returns to IDLE the following cycle. No back-to-back accept occurs in the ack cycle.
REQ-021 late_flush forces the FSM to IDLE at the next edge from any state; cdb_req is gated low combinationally in the flush cycle, and any div_start in that cycle is ignored.
REQ-022 bra_done && bra_mispredict && |(ebr_mask & bra_id) kills the held operation: FSM to IDLE at the next edge, cdb_req gated low that cycle. The same test applied to div_in.ebr_mask drops an incoming div_start.
REQ-023 bra_done && !bra_mispredict clears the bra_id bit in the held ebr_mask, including in the cycle the mask is latched from div_in.
REQ-024 cdb_rd_v is unspecified while cdb_req is low.

Reset
REQ-025 On rst: FSM IDLE, counter 0, held ebr_mask 0, div_ready 1, cdb_req 0; datapath registers are don't-care.
REQ-026 Reset asserted mid-CALC or mid-DONE abandons the operation with no CDB request afterward.

Configuration
REQ-027 DIV_SPECIAL_BYPASS_EN defined: divisor-0 and overflow cases skip CALC, so IDLE goes directly to DONE and cdb_req is high in cycle 1.
REQ-028 DIV_SPECIAL_BYPASS_EN undefined: these cases take the full REQ-017 latency with identical REQ-019 results.

Verification
REQ-029 DIVU 100/7, cdb_ack tied high -> cdb_req high only in cycle 33, cdb_rd_v=14; div_ready high in cycle 34.
REQ-030 REM -7 by 2 -> cdb_rd_v=0xFFFFFFFF (-1). DIV -7 by 2 -> 0xFFFFFFFD (-3).
REQ-031 DIV 5 by 0 -> 0xFFFFFFFF; DIV 0x80000000 by -1 -> 0x80000000. Run both with and without DIV_SPECIAL_BYPASS_EN and check cycle 1 vs cycle 33 completion.
REQ-032 cdb_ack held low 10 cycles after result -> cdb_req and cdb_* stable for all 10 cycles; one handoff only.
REQ-033 ebr_mask=0b0010; bra_done+mispredict with bra_id=0b0010 in cycle 10 -> no cdb_req ever, div_ready high in cycle 11. Repeat with bra_id=0b0100 -> normal completion.
REQ-034 late_flush in DONE cycle 33 -> cdb_req low that cycle, IDLE in cycle 34. rst pulse in cycle 5 -> div_ready high immediately, no result.
